dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single word-wide data memory between two masters.
- Port 0 is the CPU MEM stage; port 1 is the debug/loader master.
- Round-robin arbitration, one access per cycle.
- Byte-enable stores are done as read-merge-write, because the memory has only a full-word write enable.
- Sits between the masters and the data memory, whose reads are combinational and whose writes land at posedge clk when mem_we is high.

Parameters:
- MEM_BYTES, 4096, size of the memory in bytes. Any address >= MEM_BYTES is out of range.
- DATA_W, 32, word width. Byte enables are DATA_W/8 bits wide.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = store, 0 = load
- addr0 / addr1  in  32  byte address. Bits [1:0] are ignored.
- wdata0 / wdata1  in  32  store data
- be0 / be1  in  4  byte enables. be[k] covers bits [8k+7:8k].
- gnt0 / gnt1  out  1  combinational; request accepted this cycle
- rvalid0 / rvalid1  out  1  load data valid, one-cycle pulse
- rdata0 / rdata1  out  32  load data, registered
- err0 / err1  out  1  out-of-range access, one-cycle pulse
- mem_addr  out  32  word-aligned address to memory, {addr[31:2],2'b00}
- mem_wdata  out  32  data to memory
- mem_we  out  1  memory write enable
- mem_rdata  in  32  combinational memory read data

Behaviour:
- Reset values:
  - Outputs: all gnt/rvalid/err = 0, rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Internal: state = IDLE, last_grant = 1, so port 0 wins the first tie.
- Handshake: a master holds req, we, addr, wdata and be stable until it samples gnt=1 at a posedge. It may drop req or present a new request in the next cycle.
- States:
  - IDLE: grants may be issued.
  - MERGE: second cycle of a partial store. No grants; gnt0 = gnt1 = 0.
- Arbitration (IDLE only):
  - Exactly one request: grant it.
  - Both request: grant the port not equal to last_grant.
  - last_grant is updated at every grant.
- Granted load:
  - mem_addr driven in the grant cycle.
  - mem_rdata registered into rdata of the granted port.
  - rvalid pulses in cycle N+1. Latency is 1 cycle.
  - rdata holds its value until the next load on that port.
- Granted full store (be = 4'b1111): mem_we = 1 and mem_wdata = wdata in the grant cycle. Stays in IDLE.
- Granted partial store (be not 0000, not 1111), cycle N:
  - mem_addr driven; mem_rdata captured into the merge register.
  - Target address, wdata and be latched; move to MERGE.
- MERGE state, cycle N+1:
  - mem_addr = latched address; mem_we = 1.
  - mem_wdata per byte lane = be[k] ? wdata byte : merge-register byte.
  - Return to IDLE.
  - The earliest next grant is in cycle N+2.
- be = 0000 store: granted, with no mem_we and no state change.
- Out of range (addr >= MEM_BYTES):
  - Granted normally.
  - No mem_we; no MERGE state for stores.
  - Loads return rvalid with rdata = 0.
  - err of that port pulses in cycle N+1.
- Idle outputs: with no grant and not in MERGE, mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Simultaneous store and load to the same word in consecutive grants: the load granted in cycle N+1 after a full store in cycle N sees the new data, because memory updates at the posedge.
- Load after a partial store: it cannot be granted before cycle N+2, so it sees the merged word.
- Reset asserted during MERGE:
  - The pending write is discarded; mem_we = 0 in the reset cycle.
  - State goes to IDLE; last_grant goes to 1.
  - Pending rvalid/err pulses are cancelled.

Test Plan:
- Full-word store and load on port 0:
  - Stimulus: port 0 stores 0xDEADBEEF to 0x10 with be = 1111, then loads 0x10.
  - Required: mem_we = 1 in the store grant cycle; rvalid0 one cycle after the load grant, with rdata0 = 0xDEADBEEF.
- Partial store merge:
  - Stimulus: word 0x20 holds 0x11223344; port 1 stores 0xAABBCCDD with be = 0101.
  - Required: gnt1 = 1, then one MERGE cycle with mem_we = 1 and mem_wdata = 0x11BB33DD. A port 0 request during MERGE is held off.
- Round-robin fairness:
  - Stimulus: req0 = req1 = 1 continuously with full-word loads.
  - Required: grants alternate 0,1,0,1…, starting with port 0 after reset.
- Out-of-range access:
  - Stimulus: port 0 loads 0x1000; port 1 stores to 0x2000.
  - Required: err0 / err1 pulse one cycle after their grants; rdata0 = 0; mem_we never asserted.
- Reset during MERGE:
  - Stimulus: a partial store to 0x30 is granted, and reset is asserted in the MERGE cycle.
  - Required: no mem_we, and memory 0x30 is unchanged.
  - Required: after reset releases, simultaneous requests grant port 0 first.
- be = 0000 store:
  - Stimulus: port 0 stores with be = 0000.
  - Required: gnt0 = 1, mem_we = 0, and port 1 can be granted in the next cycle.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - round-robin two-master arbiter for the word-wide data memory
module dm_port_arbiter #(
   parameter int MEM_BYTES = 4096,
   parameter int DATA_W    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [31:0]           addr0,
   input  logic [DATA_W-1:0]     wdata0,
   input  logic [DATA_W/8-1:0]   be0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [31:0]           addr1,
   input  logic [DATA_W-1:0]     wdata1,
   input  logic [DATA_W/8-1:0]   be1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_W-1:0]     rdata0,
   output logic [DATA_W-1:0]     rdata1,
   output logic                  err0,
   output logic                  err1,
   output logic [31:0]           mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_we,
   input  logic [DATA_W-1:0]     mem_rdata
);
   localparam int BE_W = DATA_W / 8;

   typedef enum logic {IDLE, MERGE} state_t;

   state_t              state_q, state_d;
   logic                last_grant;
   logic                g0, g1;
   logic                start_merge;
   logic                s_we, s_inr;
   logic [31:0]         s_addr;
   logic [DATA_W-1:0]   s_wdata;
   logic [BE_W-1:0]     s_be;
   logic [31:0]         m_addr;
   logic [DATA_W-1:0]   m_wdata, m_rdata, merged;
   logic [BE_W-1:0]     m_be;

   // Ties go to the port that was not granted last; no grants while a merge write is pending.
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (!reset && state_q == IDLE) begin
         if (req0 && (!req1 || last_grant))
            g0 = 1'b1;
         else if (req1)
            g1 = 1'b1;
      end
   end

   assign gnt0    = g0;
   assign gnt1    = g1;
   assign s_we    = g1 ? we1    : we0;
   assign s_addr  = g1 ? addr1  : addr0;
   assign s_wdata = g1 ? wdata1 : wdata0;
   assign s_be    = g1 ? be1    : be0;
   assign s_inr   = s_addr < 32'(MEM_BYTES);

   always_comb begin
      merged = '0;
      for (int k = 0; k < BE_W; k++)
         merged[8*k +: 8] = m_be[k] ? m_wdata[8*k +: 8] : m_rdata[8*k +: 8];
   end

   always_comb begin
      state_d     = state_q;
      start_merge = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_we      = 1'b0;
      if (!reset) begin
         if (state_q == MERGE) begin
            mem_addr  = m_addr;
            mem_wdata = merged;
            mem_we    = 1'b1;
            state_d   = IDLE;
         end else if (g0 || g1) begin
            mem_addr = {s_addr[31:2], 2'b00};
            if (s_we && s_inr) begin
               if (&s_be) begin
                  mem_we    = 1'b1;
                  mem_wdata = s_wdata;
               end else if (|s_be) begin
                  start_merge = 1'b1;
                  state_d     = MERGE;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         last_grant <= 1'b1;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_rdata    <= '0;
         m_be       <= '0;
      end else begin
         state_q <= state_d;
         rvalid0 <= g0 && !we0;
         rvalid1 <= g1 && !we1;
         err0    <= g0 && !s_inr;
         err1    <= g1 && !s_inr;
         if (g0 && !we0)
            rdata0 <= s_inr ? mem_rdata : '0;
         if (g1 && !we1)
            rdata1 <= s_inr ? mem_rdata : '0;
         if (g0)
            last_grant <= 1'b0;
         else if (g1)
            last_grant <= 1'b1;
         if (start_merge) begin
            m_addr  <= {s_addr[31:2], 2'b00};
            m_wdata <= s_wdata;
            m_be    <= s_be;
            m_rdata <= mem_rdata;
         end
      end
   end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - self-checking bench for dm_port_arbiter
module tb_dm_port_arbiter;
   logic        clk;
   logic        reset;
   logic [1:0]  p_req, p_we;
   logic [31:0] p_addr [2];
   logic [31:0] p_wdata [2];
   logic [3:0]  p_be [2];
   logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
   logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];

   int total = 0;
   int bad   = 0;

   bit          m_busy, m_last;
   logic [9:0]  m_idx;
   logic [31:0] m_maddr, m_old;
   bit [1:0]    exp_rv, exp_err, e_g;
   logic [31:0] exp_rdata [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dm_port_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(p_req[0]), .we0(p_we[0]), .addr0(p_addr[0]), .wdata0(p_wdata[0]), .be0(p_be[0]),
      .req1(p_req[1]), .we1(p_we[1]), .addr1(p_addr[1]), .wdata1(p_wdata[1]), .be1(p_be[1]),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   assign mem_rdata = mem[mem_addr[11:2]];
   always @(posedge clk)
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++)
         if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
      return r;
   endfunction

   task automatic drive(input int p, input bit req, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      p_req[p]   = req;
      p_we[p]    = we;
      p_addr[p]  = addr;
      p_wdata[p] = wdata;
      p_be[p]    = be;
   endtask

   // Predicts grants and memory-side outputs for the current cycle and compares them.
   task automatic sample();
      int p;
      bit inr, wr;
      @(negedge clk);
      e_g = 2'b00;
      if (!reset && !m_busy) begin
         if (p_req == 2'b11) e_g[m_last ^ 1'b1] = 1'b1;
         else e_g = p_req;
      end
      chk("gnt0", gnt0, 32'(e_g[0]));
      chk("gnt1", gnt1, 32'(e_g[1]));
      chk("rvalid0", rvalid0, 32'(exp_rv[0]));
      chk("rvalid1", rvalid1, 32'(exp_rv[1]));
      chk("err0", err0, 32'(exp_err[0]));
      chk("err1", err1, 32'(exp_err[1]));
      chk("rdata0", rdata0, exp_rdata[0]);
      chk("rdata1", rdata1, exp_rdata[1]);
      p   = e_g[1] ? 1 : 0;
      inr = p_addr[p] < 32'd4096;
      if (m_busy && !reset) begin
         chk("merge_we", mem_we, 1);
         chk("merge_addr", mem_addr, m_maddr);
         chk("merge_wdata", mem_wdata, ref_mem[m_idx]);
      end else if (|e_g) begin
         wr = p_we[p] && inr && p_be[p] == 4'hf;
         chk("grant_addr", mem_addr, {p_addr[p][31:2], 2'b00});
         chk("grant_we", mem_we, 32'(wr));
         if (wr) chk("grant_wdata", mem_wdata, p_wdata[p]);
      end else begin
         chk("idle_we", mem_we, 0);
         chk("idle_addr", mem_addr, 0);
         chk("idle_wdata", mem_wdata, 0);
      end
   endtask

   // Advances the reference model across the clock edge.
   task automatic commit();
      int p;
      bit inr;
      logic [9:0] idx;
      @(posedge clk);
      if (reset) begin
         if (m_busy) ref_mem[m_idx] = m_old;
         m_busy = 0;
         m_last = 1;
         exp_rv = 0;
         exp_err = 0;
         exp_rdata[0] = 0;
         exp_rdata[1] = 0;
      end else begin
         m_busy = 0;
         exp_rv = 0;
         exp_err = 0;
         if (|e_g) begin
            p   = e_g[1] ? 1 : 0;
            inr = p_addr[p] < 32'd4096;
            idx = p_addr[p][11:2];
            m_last = e_g[1];
            if (!inr) exp_err[p] = 1;
            if (!p_we[p]) begin
               exp_rv[p] = 1;
               exp_rdata[p] = inr ? ref_mem[idx] : 32'h0;
            end else if (inr && p_be[p] != 4'h0) begin
               m_old = ref_mem[idx];
               ref_mem[idx] = apply_be(m_old, p_wdata[p], p_be[p]);
               if (p_be[p] != 4'hf) begin
                  m_busy  = 1;
                  m_idx   = idx;
                  m_maddr = {p_addr[p][31:2], 2'b00};
               end
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample();
      commit();
      reset = 1'b0;
   endtask

   task automatic rand_req(input int p);
      int r;
      logic [31:0] a;
      logic [3:0] be;
      r = $urandom_range(0, 19);
      a = (r == 0) ? 32'h1000 + 32'($urandom_range(0, 4095)) : 32'($urandom_range(0, 63));
      r = $urandom_range(0, 3);
      be = (r == 0) ? 4'h0 : (r == 1) ? 4'hf : 4'($urandom_range(1, 14));
      drive(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, be);
   endtask

   initial begin
      logic [31:0] w, old_w;
      reset = 1'b1;
      p_req = 2'b00;
      for (int p = 0; p < 2; p++) drive(p, 0, 0, 0, 0, 0);
      for (int i = 0; i < 1024; i++) begin
         w = $urandom;
         mem[i] <= w;
         ref_mem[i] = w;
      end
      m_busy = 0; m_last = 1; exp_rv = 0; exp_err = 0; e_g = 0;
      exp_rdata[0] = 0; exp_rdata[1] = 0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // full-word store then load on port 0
      drive(0, 1, 1, 32'h10, 32'hDEADBEEF, 4'hf);
      sample();
      chk("t1_gnt0", gnt0, 1);
      chk("t1_we", mem_we, 1);
      chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
      commit();
      drive(0, 1, 0, 32'h10, 0, 4'hf);
      sample(); commit();
      drive(0, 0, 0, 0, 0, 0);
      sample();
      chk("t1_rvalid0", rvalid0, 1);
      chk("t1_rdata0", rdata0, 32'hDEADBEEF);
      commit();

      // partial store merge, port 0 held off during MERGE
      drive(0, 1, 1, 32'h20, 32'h11223344, 4'hf);
      sample(); commit();
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
      sample();
      chk("t2_gnt1", gnt1, 1);
      chk("t2_nowe", mem_we, 0);
      commit();
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 32'h20, 0, 4'hf);
      sample();
      chk("t2_hold0", gnt0, 0);
      chk("t2_we", mem_we, 1);
      chk("t2_wdata", mem_wdata, 32'h11BB33DD);
      commit();
      sample();
      chk("t2_gnt0", gnt0, 1);
      commit();
      drive(0, 0, 0, 0, 0, 0);
      sample();
      chk("t2_rdata0", rdata0, 32'h11BB33DD);
      commit();

      // round robin from reset
      do_reset();
      drive(0, 1, 0, 32'h0, 0, 4'hf);
      drive(1, 1, 0, 32'h4, 0, 4'hf);
      for (int i = 0; i < 6; i++) begin
         sample();
         chk("t3_rr0", gnt0, 32'(i % 2 == 0));
         chk("t3_rr1", gnt1, 32'(i % 2 == 1));
         commit();
      end
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      sample(); commit();

      // out-of-range accesses
      drive(0, 1, 0, 32'h1000, 0, 4'hf);
      sample();
      chk("t4_gnt0", gnt0, 1);
      commit();
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 32'h2000, 32'h12345678, 4'hf);
      sample();
      chk("t4_err0", err0, 1);
      chk("t4_rdata0", rdata0, 0);
      chk("t4_gnt1", gnt1, 1);
      chk("t4_we", mem_we, 0);
      commit();
      drive(1, 0, 0, 0, 0, 0);
      sample();
      chk("t4_err1", err1, 1);
      commit();

      // reset during MERGE
      old_w = mem[12];
      drive(0, 1, 1, 32'h30, 32'hCAFEF00D, 4'b0011);
      sample();
      chk("t5_gnt0", gnt0, 1);
      commit();
      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      sample();
      chk("t5_we", mem_we, 0);
      commit();
      reset = 1'b0;
      drive(0, 1, 0, 32'h30, 0, 4'hf);
      drive(1, 1, 0, 32'h34, 0, 4'hf);
      sample();
      chk("t5_gnt0", gnt0, 1);
      chk("t5_gnt1", gnt1, 0);
      chk("t5_mem", mem[12], old_w);
      commit();
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      sample();
      chk("t5_rdata0", rdata0, old_w);
      commit();

      // be = 0000 store
      drive(0, 1, 1, 32'h8, 32'hFFFFFFFF, 4'h0);
      sample();
      chk("t6_gnt0", gnt0, 1);
      chk("t6_we", mem_we, 0);
      commit();
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 32'h8, 0, 4'hf);
      sample();
      chk("t6_gnt1", gnt1, 1);
      commit();
      drive(1, 0, 0, 0, 0, 0);
      sample(); commit();

      // randomized traffic with occasional reset
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         sample();
         commit();
         for (int p = 0; p < 2; p++)
            if (e_g[p] || !p_req[p]) begin
               if ($urandom_range(0, 3) != 0) rand_req(p);
               else drive(p, 0, 0, 0, 0, 0);
            end
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      repeat (2) begin
         sample();
         commit();
      end
      for (int i = 0; i < 1024; i++) chk("mem_final", mem[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
